multi_cycle_sequencer: RTL and testbench
========================================

MULTI_CYCLE_SEQUENCER -- requirements
Module: multi_cycle_sequencer

Interface
REQ-001 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port Start  input  1  program start request, sampled in IDLE and HALT only.
REQ-004 SHALL have port Ack  input  1  decoder "done w/ program" flag.
REQ-005 SHALL have port LoadInst  input  1  decoder load flag.
REQ-006 SHALL have port MemWrEn  input  1  decoder store flag.
REQ-007 SHALL have port RegWrEn  input  1  decoder reg_file write flag.
REQ-008 SHALL have port MemReady  input  1  data memory completion handshake.
REQ-009 SHALL have port IrLoad  output  1  instruction register load strobe.
REQ-010 SHALL have port MemReq  output  1  data memory access request, held until MemReady.
REQ-011 SHALL have port MemWrStrobe  output  1  store qualifier, valid with MemReq.
REQ-012 SHALL have port RegWrStrobe  output  1  reg_file write strobe.
REQ-013 SHALL have port PcUpdate  output  1  program counter advance/branch commit strobe.
REQ-014 SHALL have port Busy  output  1  high in any state other than IDLE and HALT.
REQ-015 SHALL have port Done  output  1  high in HALT.
REQ-016 SHALL have port Err  output  1  memory timeout flag (see Configuration).
REQ-017 SHALL have port RetiredCnt  output  16  instructions retired since last Start.

Function
REQ-018 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, one per cycle except where MEM waits.
REQ-019 IDLE: Start=1 -> FETCH; else stay.
REQ-020 FETCH: IrLoad=1 for exactly one cycle -> DECODE.
REQ-021 DECODE: SHALL latch LoadInst, MemWrEn, RegWrEn into internal flags; Ack=1 -> HALT (no WB, no count); else -> EXEC.
REQ-022 EXEC: latched LoadInst or MemWrEn -> MEM; else -> WB.
REQ-023 MEM: MemReq=1 every cycle; MemWrStrobe = latched MemWrEn; MemReady=1 -> WB; else stay.
REQ-024 WB: PcUpdate=1; RegWrStrobe = latched RegWrEn and not latched MemWrEn; RetiredCnt += 1, saturating at 16'hFFFF; -> FETCH.
REQ-025 HALT: Done=1; Start=1 -> FETCH, clears RetiredCnt and Err in the same edge.
REQ-026 Start SHALL be ignored while Busy=1; MemReady SHALL be ignored outside MEM.
REQ-027 All outputs SHALL be decoded from registered state/flags only (no combinational path from inputs to outputs).
REQ-028 Decoder inputs SHALL be used only as sampled in DECODE; later changes have no effect on the current instruction.
REQ-029 Non-memory instruction latency SHALL be 4 cycles FETCH->FETCH; memory instruction 5 + (wait cycles).

Reset
REQ-030 Reset=0 SHALL force IDLE immediately, independent of Clk, from any state including MEM mid-wait.
REQ-031 During/after reset all outputs SHALL be 0, RetiredCnt = 0, latched flags = 0.
REQ-032 First transition after Reset deasserts SHALL occur on a rising Clk edge only.

Configuration
REQ-033 Macro SEQ_MEM_TIMEOUT_EN: when defined, a 4-bit wait counter SHALL clear on MEM entry, increment each MEM cycle with MemReady=0, and on reaching 15 SHALL set Err=1 and go to HALT (no WB, no count).
REQ-034 Without SEQ_MEM_TIMEOUT_EN: MEM waits indefinitely, Err SHALL be tied 0, and no wait counter exists.

Verification
REQ-035 Reset, Start pulse, ALU op (RegWrEn=1), then Ack -> IrLoad at cycles 1 and 5, RegWrStrobe/PcUpdate at cycle 4, Done=1 at cycle 7, RetiredCnt=1.
REQ-036 Load (LoadInst=1, RegWrEn=1), MemReady delayed 3 cycles -> MemReq high 4 cycles, MemWrStrobe=0, RegWrStrobe=1 in WB, RetiredCnt=1.
REQ-037 Store (MemWrEn=1, RegWrEn=1), MemReady immediate -> MemWrStrobe=1 with MemReq one cycle, RegWrStrobe=0 in WB.
REQ-038 Reset=0 asserted mid-MEM between clock edges -> state IDLE and MemReq=0 before next edge; Start pulse during Busy ignored.
REQ-039 With SEQ_MEM_TIMEOUT_EN, MemReady held 0 -> Err=1 and Done=1 after 15 wait cycles; Start -> Err=0, RetiredCnt=0.
REQ-040 65537 retired ALU instructions -> RetiredCnt holds 16'hFFFF.

Source files
------------

// File: rtl/multi_cycle_sequencer.sv
// Purpose: multi-cycle instruction sequencer (IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT) that drives IR, memory, reg-file and PC strobes.
// Latency: 4 cycles FETCH->FETCH for non-memory instructions, 5 + wait cycles for loads/stores.
// Backpressure: MEM holds MemReq until MemReady; with SEQ_MEM_TIMEOUT_EN defined, 15 wait cycles abort to HALT with Err set.
module multi_cycle_sequencer (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Ack,
    input  logic        LoadInst,
    input  logic        MemWrEn,
    input  logic        RegWrEn,
    input  logic        MemReady,
    output logic        IrLoad,
    output logic        MemReq,
    output logic        MemWrStrobe,
    output logic        RegWrStrobe,
    output logic        PcUpdate,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic [15:0] RetiredCnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t state;

    // Decoder flags captured in DECODE; they describe the instruction in flight
    // and ignore any later movement on the decoder inputs.
    logic ld_f;
    logic st_f;
    logic rw_f;

`ifdef SEQ_MEM_TIMEOUT_EN
    // Counts MEM cycles that saw no MemReady; the 15th such cycle aborts.
    logic [3:0] wait_cnt;
`else
    // Without the timeout the memory may stall forever and no error can occur.
    assign Err = 1'b0;
`endif

    // Sequencer: state, latched decoder flags, retire counter and all
    // outputs are registered together. Every output is set for the state
    // being entered, so outputs never see a combinational input path.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= S_IDLE;
            ld_f        <= 1'b0;
            st_f        <= 1'b0;
            rw_f        <= 1'b0;
            IrLoad      <= 1'b0;
            MemReq      <= 1'b0;
            MemWrStrobe <= 1'b0;
            RegWrStrobe <= 1'b0;
            PcUpdate    <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            RetiredCnt  <= 16'd0;
`ifdef SEQ_MEM_TIMEOUT_EN
            Err         <= 1'b0;
            wait_cnt    <= 4'd0;
`endif
        end else begin
            // Single-cycle strobes fall unless the next state re-asserts them.
            IrLoad      <= 1'b0;
            MemReq      <= 1'b0;
            MemWrStrobe <= 1'b0;
            RegWrStrobe <= 1'b0;
            PcUpdate    <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state  <= S_FETCH;
                        IrLoad <= 1'b1;
                        Busy   <= 1'b1;
                    end
                end

                S_FETCH: begin
                    state <= S_DECODE;
                end

                S_DECODE: begin
                    ld_f <= LoadInst;
                    st_f <= MemWrEn;
                    rw_f <= RegWrEn;
                    if (Ack) begin
                        // End of program: nothing retires for this slot.
                        state <= S_HALT;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end else begin
                        state <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (ld_f || st_f) begin
                        state       <= S_MEM;
                        MemReq      <= 1'b1;
                        MemWrStrobe <= st_f;
`ifdef SEQ_MEM_TIMEOUT_EN
                        wait_cnt    <= 4'd0;
`endif
                    end else begin
                        state       <= S_WB;
                        PcUpdate    <= 1'b1;
                        RegWrStrobe <= rw_f && !st_f;
                    end
                end

                S_MEM: begin
                    if (MemReady) begin
                        state       <= S_WB;
                        PcUpdate    <= 1'b1;
                        // Stores never write the register file.
                        RegWrStrobe <= rw_f && !st_f;
`ifdef SEQ_MEM_TIMEOUT_EN
                    end else if (wait_cnt == 4'd14) begin
                        // This is the 15th unanswered cycle: abandon the access.
                        wait_cnt <= wait_cnt + 4'd1;
                        state    <= S_HALT;
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                        Err      <= 1'b1;
                    end else begin
                        wait_cnt    <= wait_cnt + 4'd1;
                        MemReq      <= 1'b1;
                        MemWrStrobe <= st_f;
`else
                    end else begin
                        MemReq      <= 1'b1;
                        MemWrStrobe <= st_f;
`endif
                    end
                end

                S_WB: begin
                    if (RetiredCnt != 16'hFFFF) begin
                        RetiredCnt <= RetiredCnt + 16'd1;
                    end
                    state  <= S_FETCH;
                    IrLoad <= 1'b1;
                end

                S_HALT: begin
                    if (Start) begin
                        // Restart begins a fresh program: clear the statistics.
                        state      <= S_FETCH;
                        IrLoad     <= 1'b1;
                        Busy       <= 1'b1;
                        Done       <= 1'b0;
                        RetiredCnt <= 16'd0;
`ifdef SEQ_MEM_TIMEOUT_EN
                        Err        <= 1'b0;
`endif
                    end
                end

                default: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
// Directed bench for multi_cycle_sequencer: ALU, load, store, async reset,
// memory stall/timeout and retire-counter saturation.
module tb_multi_cycle_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Ack;
    logic        LoadInst;
    logic        MemWrEn;
    logic        RegWrEn;
    logic        MemReady;
    logic        IrLoad;
    logic        MemReq;
    logic        MemWrStrobe;
    logic        RegWrStrobe;
    logic        PcUpdate;
    logic        Busy;
    logic        Done;
    logic        Err;
    logic [15:0] RetiredCnt;

    int errors = 0;
    int checks = 0;

    // Output bundle: {IrLoad, MemReq, MemWrStrobe, RegWrStrobe, PcUpdate, Busy, Done, Err}
    logic [7:0] outs;
    assign outs = {IrLoad, MemReq, MemWrStrobe, RegWrStrobe, PcUpdate, Busy, Done, Err};

    localparam logic [7:0] O_NONE  = 8'h00;
    localparam logic [7:0] O_FETCH = 8'h84;  // IrLoad + Busy
    localparam logic [7:0] O_BUSY  = 8'h04;  // DECODE / EXEC
    localparam logic [7:0] O_WBREG = 8'h1C;  // RegWrStrobe + PcUpdate + Busy
    localparam logic [7:0] O_WBST  = 8'h0C;  // PcUpdate + Busy
    localparam logic [7:0] O_MEMRD = 8'h44;  // MemReq + Busy
    localparam logic [7:0] O_MEMWR = 8'h64;  // MemReq + MemWrStrobe + Busy
    localparam logic [7:0] O_HALT  = 8'h02;  // Done
    localparam logic [7:0] O_ABORT = 8'h03;  // Done + Err

    multi_cycle_sequencer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Ack         (Ack),
        .LoadInst    (LoadInst),
        .MemWrEn     (MemWrEn),
        .RegWrEn     (RegWrEn),
        .MemReady    (MemReady),
        .IrLoad      (IrLoad),
        .MemReq      (MemReq),
        .MemWrStrobe (MemWrStrobe),
        .RegWrStrobe (RegWrStrobe),
        .PcUpdate    (PcUpdate),
        .Busy        (Busy),
        .Done        (Done),
        .Err         (Err),
        .RetiredCnt  (RetiredCnt)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b0; Start = 1'b0; Ack = 1'b0; LoadInst = 1'b0;
        MemWrEn = 1'b0; RegWrEn = 1'b0; MemReady = 1'b0;

        // Reset state
        #2;
        chk("reset_outs", {8'h00, outs}, {8'h00, O_NONE});
        chk("reset_cnt", RetiredCnt, 16'd0);
        tick(); tick();
        chk("reset_held_outs", {8'h00, outs}, {8'h00, O_NONE});
        Reset = 1'b1;

        // ALU instruction then Ack; cycle 1 = FETCH
        Start = 1'b1; RegWrEn = 1'b1;
        tick();                                   // cycle 1
        chk("alu_c1_fetch", {8'h00, outs}, {8'h00, O_FETCH});
        Start = 1'b0;
        tick();                                   // cycle 2 DECODE
        chk("alu_c2_decode", {8'h00, outs}, {8'h00, O_BUSY});
        tick();                                   // cycle 3 EXEC
        chk("alu_c3_exec", {8'h00, outs}, {8'h00, O_BUSY});
        // Late decoder changes and Start while busy must be ignored
        RegWrEn = 1'b0; LoadInst = 1'b1; MemWrEn = 1'b1; Start = 1'b1;
        tick();                                   // cycle 4 WB
        chk("alu_c4_wb", {8'h00, outs}, {8'h00, O_WBREG});
        chk("alu_c4_cnt", RetiredCnt, 16'd0);
        Start = 1'b0; LoadInst = 1'b0; MemWrEn = 1'b0; Ack = 1'b1;
        tick();                                   // cycle 5 FETCH
        chk("alu_c5_fetch", {8'h00, outs}, {8'h00, O_FETCH});
        chk("alu_c5_cnt", RetiredCnt, 16'd1);
        tick();                                   // cycle 6 DECODE
        chk("ack_c6_decode", {8'h00, outs}, {8'h00, O_BUSY});
        tick();                                   // cycle 7 HALT
        chk("ack_c7_halt", {8'h00, outs}, {8'h00, O_HALT});
        chk("ack_c7_cnt", RetiredCnt, 16'd1);
        tick();
        chk("halt_stays", {8'h00, outs}, {8'h00, O_HALT});

        // Load with MemReady delayed 3 cycles
        Ack = 1'b0; LoadInst = 1'b1; RegWrEn = 1'b1; MemWrEn = 1'b0; Start = 1'b1;
        tick();
        chk("ld_fetch", {8'h00, outs}, {8'h00, O_FETCH});
        chk("ld_cnt_cleared", RetiredCnt, 16'd0);
        Start = 1'b0;
        tick();                                   // DECODE
        tick();                                   // EXEC
        chk("ld_exec", {8'h00, outs}, {8'h00, O_BUSY});
        MemReady = 1'b1;                          // sampled in EXEC: must be ignored
        tick();                                   // MEM 1
        chk("ld_mem1", {8'h00, outs}, {8'h00, O_MEMRD});
        MemReady = 1'b0;
        tick();                                   // MEM 2
        chk("ld_mem2", {8'h00, outs}, {8'h00, O_MEMRD});
        tick();                                   // MEM 3
        chk("ld_mem3", {8'h00, outs}, {8'h00, O_MEMRD});
        tick();                                   // MEM 4
        chk("ld_mem4", {8'h00, outs}, {8'h00, O_MEMRD});
        MemReady = 1'b1;
        tick();                                   // WB
        chk("ld_wb", {8'h00, outs}, {8'h00, O_WBREG});
        MemReady = 1'b0; Ack = 1'b1;
        tick();
        chk("ld_next_fetch", {8'h00, outs}, {8'h00, O_FETCH});
        chk("ld_cnt", RetiredCnt, 16'd1);
        tick(); tick();
        chk("ld_halt", {8'h00, outs}, {8'h00, O_HALT});

        // Store with immediate MemReady
        Ack = 1'b0; LoadInst = 1'b0; MemWrEn = 1'b1; RegWrEn = 1'b1; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick(); tick();                           // DECODE, EXEC
        MemReady = 1'b1;
        tick();                                   // MEM
        chk("st_mem", {8'h00, outs}, {8'h00, O_MEMWR});
        tick();                                   // WB
        chk("st_wb", {8'h00, outs}, {8'h00, O_WBST});
        MemReady = 1'b0; LoadInst = 1'b1; MemWrEn = 1'b0;
        tick();                                   // FETCH of a load
        chk("st_cnt", RetiredCnt, 16'd1);

        // Async reset in the middle of a memory wait
        tick(); tick();                           // DECODE, EXEC
        tick();                                   // MEM 1
        chk("ar_mem1", {8'h00, outs}, {8'h00, O_MEMRD});
        tick();                                   // MEM 2
        #2 Reset = 1'b0;
        #1;
        chk("ar_outs_now", {8'h00, outs}, {8'h00, O_NONE});
        chk("ar_cnt_now", RetiredCnt, 16'd0);
        #1 Reset = 1'b1;
        tick();
        chk("ar_idle_after", {8'h00, outs}, {8'h00, O_NONE});

        // Memory stall with MemReady held low
        Start = 1'b1; LoadInst = 1'b1; RegWrEn = 1'b1; MemWrEn = 1'b0; Ack = 1'b0; MemReady = 1'b0;
        tick();
        Start = 1'b0;
        tick(); tick();                           // DECODE, EXEC
        tick();                                   // MEM 1
        chk("to_mem1", {8'h00, outs}, {8'h00, O_MEMRD});
`ifdef SEQ_MEM_TIMEOUT_EN
        for (int i = 0; i < 14; i++) tick();      // MEM 15
        chk("to_mem15", {8'h00, outs}, {8'h00, O_MEMRD});
        tick();
        chk("to_abort", {8'h00, outs}, {8'h00, O_ABORT});
        chk("to_abort_cnt", RetiredCnt, 16'd0);
        LoadInst = 1'b0; Start = 1'b1;
        tick();
        chk("to_restart", {8'h00, outs}, {8'h00, O_FETCH});
        chk("to_restart_cnt", RetiredCnt, 16'd0);
        Start = 1'b0;
`else
        for (int i = 0; i < 29; i++) tick();      // MEM 30
        chk("stall_mem30", {8'h00, outs}, {8'h00, O_MEMRD});
        MemReady = 1'b1;
        tick();
        chk("stall_wb", {8'h00, outs}, {8'h00, O_WBREG});
        MemReady = 1'b0; LoadInst = 1'b0;
        tick();
        chk("stall_fetch", {8'h00, outs}, {8'h00, O_FETCH});
        chk("stall_cnt", RetiredCnt, 16'd1);
`endif

        // Saturation: preload the counter near the top instead of retiring 65k instructions
        force dut.RetiredCnt = 16'hFFFE;
        #1 release dut.RetiredCnt;
        tick(); tick(); tick();                   // DECODE, EXEC, WB
        tick();                                   // FETCH
        chk("sat_ffff", RetiredCnt, 16'hFFFF);
        tick(); tick(); tick();
        tick();
        chk("sat_hold", RetiredCnt, 16'hFFFF);
        Ack = 1'b1;
        tick(); tick();                           // DECODE, HALT
        chk("sat_halt", {8'h00, outs}, {8'h00, O_HALT});
        chk("sat_halt_cnt", RetiredCnt, 16'hFFFF);
        Ack = 1'b0; Start = 1'b1;
        tick();
        chk("sat_restart_cnt", RetiredCnt, 16'd0);
        Start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
